// File: rtl/shift_arb_pkg.sv
// shift_arb_pkg: shared direction codes and request record for the shift arbiter
package shift_arb_pkg;

   localparam logic SHIFT_LEFT  = 1'b0;
   localparam logic SHIFT_RIGHT = 1'b1;

   typedef struct packed {
      logic [7:0] data;
      logic [2:0] amt;
      logic       op;
   } shift_req_t;

endpackage

// File: rtl/shifter_8b.sv
// shifter_8b: combinational 8-bit logical shifter, left or right by 0..7
module shifter_8b
   import shift_arb_pkg::*;
(
   input  logic [7:0] in_,
   input  logic [2:0] amt,
   input  logic       op,
   output logic [7:0] out
);

   // zero-filled shift in the requested direction, truncated to 8 bits
   always_comb out = (op == SHIFT_RIGHT) ? (in_ >> amt) : (in_ << amt);

endmodule

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin arbiter sharing one 8-bit shifter among NREQ requesters
module shift_arbiter
   import shift_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [NREQ-1:0]     req_val,
   output logic [NREQ-1:0]     req_rdy,
   input  logic [NREQ*8-1:0]   req_in,
   input  logic [NREQ*3-1:0]   req_amt,
   input  logic [NREQ-1:0]     req_op,
   output logic                resp_val,
   input  logic                resp_rdy,
   output logic [7:0]          resp_out,
   output logic [IDW-1:0]      resp_id
);

   localparam int SW = IDW + 1;

   logic [IDW-1:0]    ptr;
   logic [IDW-1:0]    win;
   logic [IDW-1:0]    nxt;
   logic [2*NREQ-1:0] dbl;
   logic [SW-1:0]     idx;
   logic              found;
   logic              can_accept;
   logic              grant;
   shift_req_t        sel;
   logic [7:0]        shifted;

   // scan the doubled request vector from ptr so wrap-around needs no modulo on the index
   always_comb begin
      dbl   = {req_val, req_val};
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = SW'(ptr) + SW'(k);
         if (!found && dbl[idx]) begin
            found = 1'b1;
            win   = IDW'(idx >= SW'(NREQ) ? idx - SW'(NREQ) : idx);
         end
      end
   end

   assign can_accept = !resp_val || resp_rdy;
   assign grant      = reset_n && can_accept && found;
   assign nxt        = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;

   // one-hot accept to the winner only when the buffer can take a result
   always_comb req_rdy = grant ? (NREQ'(1) << win) : '0;

   // winner mux: only the granted requester's fields reach the shared shifter
   always_comb begin
      sel = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win == IDW'(i)) begin
            sel.data = req_in[8*i +: 8];
            sel.amt  = req_amt[3*i +: 3];
            sel.op   = req_op[i];
         end
      end
   end

   shifter_8b u_shift (
      .in_ (sel.data),
      .amt (sel.amt),
      .op  (sel.op),
      .out (shifted)
   );

   // single-entry output buffer: load on grant, clear valid on a bare drain, otherwise hold
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         resp_val <= 1'b0;
         resp_out <= 8'h00;
         resp_id  <= '0;
         ptr      <= '0;
      end else if (grant) begin
         resp_val <= 1'b1;
         resp_out <= shifted;
         resp_id  <= win;
         ptr      <= nxt;
      end else if (resp_rdy) begin
         resp_val <= 1'b0;
      end
   end

endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: vector table, corner sequences and scoreboarded random traffic
module tb_shift_arbiter;

   localparam int N  = 4;
   localparam int IW = 2;

   logic           clk = 1'b0;
   logic           reset_n = 1'b0;
   logic [N-1:0]   req_val = '0;
   logic [N-1:0]   req_rdy;
   logic [N*8-1:0] req_in = '0;
   logic [N*3-1:0] req_amt = '0;
   logic [N-1:0]   req_op = '0;
   logic           resp_val;
   logic           resp_rdy = 1'b0;
   logic [7:0]     resp_out;
   logic [IW-1:0]  resp_id;

   int total = 0;
   int bad = 0;

   typedef struct {
      logic [7:0] out;
      int         id;
   } exp_t;

   typedef struct {
      int         id;
      logic [7:0] din;
      logic [2:0] amt;
      logic       op;
      logic [7:0] dout;
   } vec_t;

   exp_t sb[$];
   int   m_ptr = 0;
   bit   m_val = 1'b0;
   vec_t vt[8];

   shift_arbiter #(.NREQ(N)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .req_val  (req_val),
      .req_rdy  (req_rdy),
      .req_in   (req_in),
      .req_amt  (req_amt),
      .req_op   (req_op),
      .resp_val (resp_val),
      .resp_rdy (resp_rdy),
      .resp_out (resp_out),
      .resp_id  (resp_id)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] model(input logic [7:0] d, input logic [2:0] a, input logic o);
      logic [15:0] t;
      t = {8'h00, d} << a;
      return o ? (d >> a) : t[7:0];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // reference arbiter and scoreboard, evaluated mid-cycle while inputs are stable
   always @(negedge clk) begin
      logic [N-1:0] er;
      int w;
      exp_t e;
      if (!reset_n) begin
         chk("rst_rdy", 32'(req_rdy), 32'd0);
         chk("rst_val", 32'(resp_val), 32'd0);
         sb.delete();
         m_ptr = 0;
         m_val = 1'b0;
      end else begin
         er = '0;
         w = -1;
         if (!m_val || resp_rdy)
            for (int k = N - 1; k >= 0; k--)
               if (req_val[(m_ptr + k) % N]) w = (m_ptr + k) % N;
         if (w >= 0) er[w] = 1'b1;
         chk("rdy", 32'(req_rdy), 32'(er));
         chk("val", 32'(resp_val), 32'(m_val));
         if (m_val && resp_rdy) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("sb_out", 32'(resp_out), 32'(e.out));
               chk("sb_id", 32'(resp_id), 32'(e.id));
            end
         end
         if (w >= 0) begin
            e.out = model(req_in[8*w +: 8], req_amt[3*w +: 3], req_op[w]);
            e.id  = w;
            sb.push_back(e);
            m_ptr = (w + 1) % N;
            m_val = 1'b1;
         end else if (resp_rdy) begin
            m_val = 1'b0;
         end
      end
   end

   initial begin
      logic [7:0] hold;
      vt[0] = '{1, 8'hA5, 3'd3, 1'b0, 8'h28};
      vt[1] = '{1, 8'hA5, 3'd3, 1'b1, 8'h14};
      vt[2] = '{0, 8'h81, 3'd0, 1'b0, 8'h81};
      vt[3] = '{0, 8'h81, 3'd0, 1'b1, 8'h81};
      vt[4] = '{2, 8'hFF, 3'd7, 1'b0, 8'h80};
      vt[5] = '{3, 8'hFF, 3'd7, 1'b1, 8'h01};
      vt[6] = '{2, 8'h3C, 3'd4, 1'b0, 8'hC0};
      vt[7] = '{3, 8'h3C, 3'd2, 1'b1, 8'h0F};

      repeat (2) step();
      chk("reset_val", 32'(resp_val), 32'd0);
      chk("reset_out", 32'(resp_out), 32'd0);
      chk("reset_id", 32'(resp_id), 32'd0);
      reset_n  = 1'b1;
      resp_rdy = 1'b1;

      for (int i = 0; i < 8; i++) begin
         req_val = '0;
         req_val[vt[i].id] = 1'b1;
         req_in[8*vt[i].id +: 8]  = vt[i].din;
         req_amt[3*vt[i].id +: 3] = vt[i].amt;
         req_op[vt[i].id]         = vt[i].op;
         #2;
         chk($sformatf("v%0d_rdy", i), 32'(req_rdy), 32'd1 << vt[i].id);
         step();
         req_val = '0;
         chk($sformatf("v%0d_val", i), 32'(resp_val), 32'd1);
         chk($sformatf("v%0d_out", i), 32'(resp_out), 32'(vt[i].dout));
         chk($sformatf("v%0d_id", i), 32'(resp_id), 32'(vt[i].id));
      end

      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      req_val = '1;
      for (int i = 0; i < N; i++) begin
         req_in[8*i +: 8]  = 8'(8'h11 * (i + 1));
         req_amt[3*i +: 3] = 3'(i);
         req_op[i]         = 1'(i);
      end
      for (int c = 0; c < 8; c++) begin
         #2;
         chk($sformatf("fair%0d_rdy", c), 32'(req_rdy), 32'd1 << (c % N));
         step();
         chk($sformatf("fair%0d_id", c), 32'(resp_id), 32'(c % N));
      end

      resp_rdy = 1'b0;
      hold = resp_out;
      for (int c = 0; c < 3; c++) begin
         #2;
         chk($sformatf("bp%0d_rdy", c), 32'(req_rdy), 32'd0);
         step();
         chk($sformatf("bp%0d_val", c), 32'(resp_val), 32'd1);
         chk($sformatf("bp%0d_id", c), 32'(resp_id), 32'd3);
         chk($sformatf("bp%0d_out", c), 32'(resp_out), 32'(hold));
      end
      resp_rdy = 1'b1;
      #2;
      chk("bp_resume_rdy", 32'(req_rdy), 32'd1);
      step();
      chk("bp_resume_val", 32'(resp_val), 32'd1);
      chk("bp_resume_id", 32'(resp_id), 32'd0);

      reset_n = 1'b0;
      #1;
      chk("arst_val", 32'(resp_val), 32'd0);
      chk("arst_out", 32'(resp_out), 32'd0);
      chk("arst_id", 32'(resp_id), 32'd0);
      chk("arst_rdy", 32'(req_rdy), 32'd0);
      step();
      reset_n = 1'b1;
      #2;
      chk("arst_prio_rdy", 32'(req_rdy), 32'd1);
      step();
      chk("arst_prio_id", 32'(resp_id), 32'd0);

      for (int c = 0; c < 10000; c++) begin
         req_val  = N'($urandom);
         req_in   = 32'($urandom);
         req_amt  = 12'($urandom);
         req_op   = N'($urandom);
         resp_rdy = ($urandom_range(3) != 0);
         step();
      end

      req_val  = '0;
      resp_rdy = 1'b1;
      repeat (3) step();
      chk("drain_sb", 32'(sb.size()), 32'd0);
      chk("drain_val", 32'(resp_val), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
